// File: rtl/mul_32b_pkg.sv
// Shared definitions for the sequential Booth multiplier.
//   MUL_WIDTH   : default operand width of mul_32b.
//   mul_state_e : controller states (idle, iterating, result held).
//   BOOTH_ADD/SUB : radix-2 Booth codes formed from {Q[0], q_1}.
package mul_32b_pkg;

  localparam int MUL_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } mul_state_e;

  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/mul_32b_booth_step.sv
// One radix-2 Booth iteration, purely combinational.
// Ports:
//   a_i   : partial-product accumulator A (WIDTH+1, signed)
//   q_i   : multiplier register Q (WIDTH+1)
//   q_1_i : bit shifted out of Q on the previous step
//   m_i   : extended multiplicand M (WIDTH+1, signed)
//   a_o, q_o, q_1_o : {A, Q, q_1} after add/subtract and arithmetic shift
module mul_32b_booth_step
  import mul_32b_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic signed [WIDTH:0] a_i,
  input  logic        [WIDTH:0] q_i,
  input  logic                  q_1_i,
  input  logic signed [WIDTH:0] m_i,
  output logic signed [WIDTH:0] a_o,
  output logic        [WIDTH:0] q_o,
  output logic                  q_1_o
);

  logic signed [WIDTH:0] sum;

  always_comb begin
    sum = a_i;
    case ({q_i[0], q_1_i})
      BOOTH_ADD: sum = a_i + m_i;
      BOOTH_SUB: sum = a_i - m_i;
      default:   sum = a_i;
    endcase
    // Arithmetic shift of {sum, Q, q_1}: sign of the updated A is replicated,
    // A's LSB moves into Q's MSB, Q's LSB becomes the new q_1.
    a_o   = {sum[WIDTH], sum[WIDTH:1]};
    q_o   = {sum[0], q_i[WIDTH:1]};
    q_1_o = q_i[0];
  end

endmodule

// File: rtl/mul_32b.sv
// Sequential WIDTH x WIDTH -> 2*WIDTH multiplier, radix-2 Booth, one step per
// cycle for WIDTH+1 cycles. Same start/done handshake as the iterative divider.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   X, Y       : multiplicand / multiplier, captured on the accepting edge
//   is_signed  : 1 = two's-complement operands, 0 = unsigned
//   in_valid   : start request, accepted when not busy
//   P          : 2*WIDTH-bit product, held until the next accept or reset
//   busy       : high while iterating
//   out_valid  : high while P holds a completed result
module mul_32b
  import mul_32b_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     X,
  input  logic [WIDTH-1:0]     Y,
  input  logic                 is_signed,
  input  logic                 in_valid,
  output logic [2*WIDTH-1:0]   P,
  output logic                 busy,
  output logic                 out_valid
);

  localparam int               CNT_W    = $clog2(WIDTH + 2);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  mul_state_e              state_q, state_d;
  logic signed [WIDTH:0]   a_q, a_d;
  logic signed [WIDTH:0]   m_q, m_d;
  logic        [WIDTH:0]   q_q, q_d;
  logic                    q1_q, q1_d;
  logic        [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0]      p_q, p_d;
  logic                    busy_q, busy_d;
  logic                    ov_q, ov_d;

  logic signed [WIDTH:0]   a_nxt;
  logic        [WIDTH:0]   q_nxt;
  logic                    q1_nxt;

  // The extra top bit makes both signed and unsigned operands valid signed
  // (WIDTH+1)-bit values, so a single Booth datapath serves both modes.
  function automatic logic [WIDTH:0] extend(input logic [WIDTH-1:0] v,
                                            input logic             sgn);
    return {sgn & v[WIDTH-1], v};
  endfunction

  mul_32b_booth_step #(.WIDTH(WIDTH)) booth_step (
    .a_i   (a_q),
    .q_i   (q_q),
    .q_1_i (q1_q),
    .m_i   (m_q),
    .a_o   (a_nxt),
    .q_o   (q_nxt),
    .q_1_o (q1_nxt)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    m_d     = m_q;
    q_d     = q_q;
    q1_d    = q1_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    busy_d  = busy_q;
    ov_d    = ov_q;

    case (state_q)
      ST_CALC: begin
        // Requests arriving here are ignored by construction.
        a_d   = a_nxt;
        q_d   = q_nxt;
        q1_d  = q1_nxt;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          ov_d    = 1'b1;
          // Low 2*WIDTH bits of the (2*WIDTH+2)-bit {A, Q}.
          p_d     = {a_nxt[WIDTH-2:0], q_nxt};
        end
      end
      default: begin
        // IDLE and DONE both accept; DONE therefore allows back-to-back use.
        if (in_valid) begin
          state_d = ST_CALC;
          m_d     = extend(X, is_signed);
          q_d     = extend(Y, is_signed);
          a_d     = '0;
          q1_d    = 1'b0;
          cnt_d   = CNT_LOAD;
          busy_d  = 1'b1;
          ov_d    = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      m_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      p_q     <= '0;
      busy_q  <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      m_q     <= m_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      busy_q  <= busy_d;
      ov_q    <= ov_d;
    end
  end

  assign P         = p_q;
  assign busy      = busy_q;
  assign out_valid = ov_q;

endmodule

// File: tb/tb_mul_32b.sv
module tb_mul_32b;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   X, Y;
  logic           is_signed, in_valid;
  logic [2*W-1:0] P;
  logic           busy, out_valid;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic check_en = 1'b0;

  // Behavioural model: product by plain arithmetic, timing by a cycle countdown.
  logic           m_busy, m_ov;
  logic [2*W-1:0] m_p, m_pending;
  int             m_rem;

  mul_32b #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .X         (X),
    .Y         (Y),
    .is_signed (is_signed),
    .in_valid  (in_valid),
    .P         (P),
    .busy      (busy),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x,
                                             input logic [W-1:0] y,
                                             input logic         s);
    if (s) return 64'(longint'($signed(x)) * longint'($signed(y)));
    return {32'd0, x} * {32'd0, y};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_ov   <= 1'b0;
      m_p    <= '0;
      m_rem  <= 0;
    end else if (in_valid && !m_busy) begin
      m_busy    <= 1'b1;
      m_ov      <= 1'b0;
      m_rem     <= W + 1;
      m_pending <= ref_mul(X, Y, is_signed);
    end else if (m_busy) begin
      if (m_rem == 1) begin
        m_busy <= 1'b0;
        m_ov   <= 1'b1;
        m_p    <= m_pending;
      end
      m_rem <= m_rem - 1;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      n_checks++;
      if (P !== m_p || busy !== m_busy || out_valid !== m_ov) begin
        n_fail++;
        $display("FAIL cycle_model t=%0t: got P=%h busy=%b out_valid=%b, want P=%h busy=%b out_valid=%b",
                 $time, P, busy, out_valid, m_p, m_busy, m_ov);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic request(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    X         = x;
    Y         = y;
    is_signed = s;
    in_valid  = 1'b1;
    step();
    in_valid  = 1'b0;
  endtask

  task automatic wait_done(input int start, output int cycles);
    cycles = start;
    while (out_valid !== 1'b1 && cycles < 200) begin
      step();
      cycles++;
    end
  endtask

  int cyc;
  int bcount;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    X         = '0;
    Y         = '0;
    is_signed = 1'b0;
    step();
    step();
    check_en = 1'b1;
    chk("reset_P", P, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    rst = 1'b0;
    step();

    // Unsigned 7 x 6, busy high for exactly WIDTH+1 sampled cycles.
    request(32'd7, 32'd6, 1'b0);
    bcount = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy === 1'b1) bcount++;
      if (out_valid === 1'b1) break;
      step();
    end
    chk("u7x6_busy_cycles", 64'(bcount), 64'd33);
    chk("u7x6_P", P, 64'd42);
    chk("u7x6_out_valid", {63'd0, out_valid}, 64'd1);
    chk("u7x6_busy_low", {63'd0, busy}, 64'd0);

    // Signed -3 x 5.
    request(32'hFFFF_FFFD, 32'd5, 1'b1);
    wait_done(0, cyc);
    chk("s_m3x5_latency", 64'(cyc), 64'd33);
    chk("s_m3x5_P", P, 64'hFFFF_FFFF_FFFF_FFF1);

    // Unsigned all-ones squared.
    request(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_done(0, cyc);
    chk("u_max_P", P, 64'hFFFF_FFFE_0000_0001);

    // Signed most-negative squared.
    request(32'h8000_0000, 32'h8000_0000, 1'b1);
    wait_done(0, cyc);
    chk("s_min_P", P, 64'h4000_0000_0000_0000);

    // Unsigned with top bit set must zero-extend.
    request(32'h8000_0000, 32'd2, 1'b0);
    wait_done(0, cyc);
    chk("u_topbit_P", P, 64'h0000_0001_0000_0000);

    // Zero operand still runs the full iteration.
    request(32'd0, 32'h1234_5678, 1'b1);
    wait_done(0, cyc);
    chk("zero_latency", 64'(cyc), 64'd33);
    chk("zero_P", P, 64'd0);

    // Request while busy is ignored.
    request(32'd3, 32'd4, 1'b0);
    repeat (9) step();
    X        = 32'd100;
    Y        = 32'd100;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_done(10, cyc);
    chk("reject_latency", 64'(cyc), 64'd33);
    chk("reject_P", P, 64'd12);

    // Reset mid-operation.
    request(32'd5, 32'd5, 1'b0);
    repeat (14) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_P", P, 64'd0);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
    step();
    request(32'd1000, 32'd1000, 1'b0);
    wait_done(0, cyc);
    chk("after_abort_P", P, 64'd1000000);

    // Back-to-back: accept in the first DONE cycle.
    request(32'd2, 32'd3, 1'b1);
    wait_done(0, cyc);
    chk("b2b_first_P", P, 64'd6);
    X         = 32'hFFFF_FFFF;
    Y         = 32'hFFFF_FFFF;
    is_signed = 1'b1;
    in_valid  = 1'b1;
    step();
    in_valid  = 1'b0;
    chk("b2b_out_valid_drop", {63'd0, out_valid}, 64'd0);
    chk("b2b_busy_rise", {63'd0, busy}, 64'd1);
    chk("b2b_P_held", P, 64'd6);
    wait_done(0, cyc);
    chk("b2b_latency", 64'(cyc), 64'd33);
    chk("b2b_second_P", P, 64'd1);

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
